// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared constants for the forwarding / load-use hazard unit:
//     REG_AW    default register-index width
//     ZERO_REG  hardwired-zero register index (never tracked, never forwarded)
//     FWD_RF    bypass select value meaning "read the register file"
//     STG_*     stage numbers used as bypass select values for the default
//               three-stage tracker (EX, MEM, WB)
// -----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ZERO_REG = 0;

  localparam int unsigned FWD_RF   = 0;
  localparam int unsigned STG_EX   = 1;
  localparam int unsigned STG_MEM  = 2;
  localparam int unsigned STG_WB   = 3;

  // Width of a bypass select able to encode 0 (regfile) .. depth.
  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// -----------------------------------------------------------------------------
// fwd_src_match
//   Bypass search for one ID-stage source operand. Compares the source index
//   against every tracked producer stage and picks the youngest (lowest stage
//   number) valid match. Flags a load-use stall when that youngest producer is
//   a load that has not yet reached the first stage where its data exists.
//
//   req_i      source is live (instruction valid and operand actually read)
//   rs_i       source register index
//   trk_vld_i  per-stage valid bits, bit k = stage k+1
//   trk_rd_i   per-stage destination indices, stage k+1 = [k*REG_AW +: REG_AW]
//   trk_ld_i   per-stage "producer is a load" bits
//   sel_o      0 = regfile, k = bypass from stage k
//   stall_o    youngest producer is a load not yet forwardable
// -----------------------------------------------------------------------------
module fwd_src_match #(
  parameter int unsigned REG_AW    = fwd_hazard_unit_pkg::REG_AW,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_RDY  = 2,
  parameter int unsigned SEL_W     = fwd_hazard_unit_pkg::sel_width(FWD_DEPTH)
) (
  input  logic                        req_i,
  input  logic [REG_AW-1:0]           rs_i,
  input  logic [FWD_DEPTH-1:0]        trk_vld_i,
  input  logic [FWD_DEPTH*REG_AW-1:0] trk_rd_i,
  input  logic [FWD_DEPTH-1:0]        trk_ld_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        stall_o
);

  import fwd_hazard_unit_pkg::*;

  logic [FWD_DEPTH-1:0] match;
  logic                 found;

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      match[k] = req_i && (rs_i != REG_AW'(ZERO_REG)) && trk_vld_i[k] &&
                 (trk_rd_i[k*REG_AW +: REG_AW] == rs_i);
    end
  end

  // Only the first (youngest) hit decides both the select and the stall, so an
  // older load shadowed by a younger ALU write never stalls.
  always_comb begin
    found   = 1'b0;
    sel_o   = SEL_W'(FWD_RF);
    stall_o = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (match[k] && !found) begin
        found   = 1'b1;
        sel_o   = SEL_W'(k + 1);
        stall_o = trk_ld_i[k] && ((k + 1) < LOAD_RDY);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit. A FWD_DEPTH-entry destination tracker
//   follows in-flight register writes (entry 1 = EX, 2 = MEM, 3 = WB by
//   default). For each ID source a bypass select is produced combinationally;
//   a load-use stall is raised when a source's youngest producer is a load
//   still short of LOAD_RDY, and stall cycles are counted with saturation.
//
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   id_valid     instruction in ID is valid
//   id_rs        source indices, source j = [j*REG_AW +: REG_AW]
//   id_rs_used   bit j = source j is actually read
//   id_rd        destination index
//   id_regwrite  instruction writes id_rd
//   id_memread   instruction is a load
//   flush        kill the instruction leaving ID
//   fwd_sel      per-source bypass select, source j = [j*SEL_W +: SEL_W]
//   stall        hold PC/IF/ID, bubble into EX
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int unsigned REG_AW    = fwd_hazard_unit_pkg::REG_AW,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_RDY  = 2,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned SEL_W    = fwd_hazard_unit_pkg::sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  import fwd_hazard_unit_pkg::*;

  logic [FWD_DEPTH-1:0]        vld_q, vld_d;
  logic [FWD_DEPTH-1:0]        ld_q,  ld_d;
  logic [FWD_DEPTH*REG_AW-1:0] rd_q,  rd_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_SRC-1:0]          src_stall;
  logic                        issue;

  // The ID instruction itself is not in the tracker yet, so a read of its own
  // destination only ever compares against older producers.
  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_src_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_RDY  (LOAD_RDY),
      .SEL_W     (SEL_W)
    ) u_match (
      .req_i     (id_valid & id_rs_used[j]),
      .rs_i      (id_rs[j*REG_AW +: REG_AW]),
      .trk_vld_i (vld_q),
      .trk_rd_i  (rd_q),
      .trk_ld_i  (ld_q),
      .sel_o     (fwd_sel[j*SEL_W +: SEL_W]),
      .stall_o   (src_stall[j])
    );
  end

  assign stall = |src_stall;

  assign issue = id_valid && id_regwrite && (id_rd != REG_AW'(ZERO_REG)) &&
                 !stall && !flush;

  // Tracker advances every cycle, stalled or not, so producers ahead keep
  // draining and the stall releases on its own.
  always_comb begin
    vld_d = '0;
    ld_d  = '0;
    rd_d  = '0;
    vld_d[0]          = issue;
    ld_d[0]           = id_memread;
    rd_d[REG_AW-1:0]  = id_rd;
    for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
      vld_d[k]                    = vld_q[k-1];
      ld_d[k]                     = ld_q[k-1];
      rd_d[k*REG_AW +: REG_AW]    = rd_q[(k-1)*REG_AW +: REG_AW];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;

  logic [3:0]  d0_sel;
  logic        d0_stall;
  logic [15:0] d0_cnt;
  logic [3:0]  d1_sel;
  logic        d1_stall;
  logic [1:0]  d1_cnt;
  logic [5:0]  d2_sel;
  logic        d2_stall;
  logic [15:0] d2_cnt;

  int checks;
  int errors;

  // Default configuration.
  fwd_hazard_unit d0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush),
    .fwd_sel(d0_sel), .stall(d0_stall), .stall_cnt(d0_cnt)
  );

  // Narrow counter for saturation.
  fwd_hazard_unit #(.CNT_W(2)) d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush),
    .fwd_sel(d1_sel), .stall(d1_stall), .stall_cnt(d1_cnt)
  );

  // Deeper tracker, late load data.
  fwd_hazard_unit #(.FWD_DEPTH(4), .LOAD_RDY(3)) d2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush),
    .fwd_sel(d2_sel), .stall(d2_stall), .stall_cnt(d2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic wr, input logic mr, input logic fl);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = wr;
    id_memread  = mr;
    flush       = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd3, 1'b1, 1'b1, 1'b0);
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0h exp=0", d0_sel); end
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", d0_stall); end
    checks++; if (d0_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", d0_cnt); end
    checks++; if (d2_sel !== 6'd0) begin errors++; $display("FAIL reset_sel_d2 got=%0h exp=0", d2_sel); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alu_alu;
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL alu_first sel got=%0h exp=0", d0_sel); end
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0);   // add r6 <- r3
    checks++; if (d0_sel[1:0] !== 2'd1) begin errors++; $display("FAIL alu_ex sel0 got=%0d exp=1", d0_sel[1:0]); end
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL alu_ex stall got=%b exp=0", d0_stall); end
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel[1:0] !== 2'd2) begin errors++; $display("FAIL alu_mem sel0 got=%0d exp=2", d0_sel[1:0]); end
    tick();
    checks++; if (d0_sel[1:0] !== 2'd3) begin errors++; $display("FAIL alu_wb sel0 got=%0d exp=3", d0_sel[1:0]); end
    tick();
    drive(1'b1, 5'd3, 5'd6, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel[1:0] !== 2'd0) begin errors++; $display("FAIL alu_drop sel0 got=%0d exp=0", d0_sel[1:0]); end
    checks++; if (d0_sel[3:2] !== 2'd3) begin errors++; $display("FAIL alu_src1 sel1 got=%0d exp=3", d0_sel[3:2]); end
  endtask

  task automatic test_load_use;
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    tick();
    drive(1'b1, 5'd1, 5'd5, 2'b10, 5'd8, 1'b1, 1'b0, 1'b0);   // uses r5 as rt
    checks++; if (d0_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", d0_stall); end
    checks++; if (d0_sel[3:2] !== 2'd1) begin errors++; $display("FAIL lu_sel_stalled got=%0d exp=1", d0_sel[3:2]); end
    tick();
    checks++; if (d0_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", d0_cnt); end
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL lu_retry_stall got=%b exp=0", d0_stall); end
    checks++; if (d0_sel[3:2] !== 2'd2) begin errors++; $display("FAIL lu_retry_sel got=%0d exp=2", d0_sel[3:2]); end
    tick();
    drive(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got=%0d exp=1", d0_cnt); end
    checks++; if (d0_sel[1:0] !== 2'd1) begin errors++; $display("FAIL lu_retry_issued sel got=%0d exp=1", d0_sel[1:0]); end
  endtask

  task automatic test_shadow;
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);   // lw r7
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);   // add r7
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel[1:0] !== 2'd1) begin errors++; $display("FAIL shadow_sel got=%0d exp=1", d0_sel[1:0]); end
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL shadow_stall got=%b exp=0", d0_stall); end
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0);   // lw r9
    tick();
    drive(1'b1, 5'd9, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);   // r9 present but unused
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%b exp=0", d0_stall); end
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL unused_sel got=%0h exp=0", d0_sel); end
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_stall !== 1'b1) begin errors++; $display("FAIL used_stall got=%b exp=1", d0_stall); end
    drive(1'b0, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL invalid_stall got=%b exp=0", d0_stall); end
  endtask

  task automatic test_zero_flush;
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);   // add r0
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL zero_sel got=%0h exp=0", d0_sel); end
    drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0); // reads its own rd
    checks++; if (d0_sel[1:0] !== 2'd0) begin errors++; $display("FAIL self_sel got=%0d exp=0", d0_sel[1:0]); end
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0, 1'b0);  // add r10
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b1);   // add r4, flushed
    tick();
    drive(1'b1, 5'd4, 5'd10, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel[1:0] !== 2'd0) begin errors++; $display("FAIL flush_sel got=%0d exp=0", d0_sel[1:0]); end
    checks++; if (d0_sel[3:2] !== 2'd2) begin errors++; $display("FAIL flush_older_sel got=%0d exp=2", d0_sel[3:2]); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);   // stalls once
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0);   // add r1
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0);   // add r2
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3
    tick();
    drive(1'b1, 5'd3, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d0_sel !== 4'b1101) begin errors++; $display("FAIL mid_pre sel got=%0h exp=d", d0_sel); end
    checks++; if (d0_stall !== 1'b1) begin errors++; $display("FAIL mid_pre stall got=%b exp=1", d0_stall); end
    checks++; if (d0_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre cnt got=%0d exp=1", d0_cnt); end
    rst_n = 1'b0;
    #2;
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL mid_rst sel got=%0h exp=0", d0_sel); end
    checks++; if (d0_stall !== 1'b0) begin errors++; $display("FAIL mid_rst stall got=%b exp=0", d0_stall); end
    checks++; if (d0_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst cnt got=%0d exp=0", d0_cnt); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (d0_sel !== 4'd0) begin errors++; $display("FAIL mid_post sel got=%0h exp=0", d0_sel); end
    tick();
  endtask

  task automatic test_saturation;
    do_reset();
    // lw r5 reading r5: stalls on every other cycle, five stalls in ten edges.
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    checks++; if (d1_cnt !== 2'd2) begin errors++; $display("FAIL sat_mid cnt got=%0d exp=2", d1_cnt); end
    repeat (6) tick();
    checks++; if (d1_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold cnt got=%0d exp=3", d1_cnt); end
    checks++; if (d0_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide cnt got=%0d exp=5", d0_cnt); end
  endtask

  task automatic test_deep_load;
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);   // lw r5
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (d2_stall !== 1'b1) begin errors++; $display("FAIL deep_stall1 got=%b exp=1", d2_stall); end
    checks++; if (d2_sel[2:0] !== 3'd1) begin errors++; $display("FAIL deep_sel1 got=%0d exp=1", d2_sel[2:0]); end
    tick();
    checks++; if (d2_stall !== 1'b1) begin errors++; $display("FAIL deep_stall2 got=%b exp=1", d2_stall); end
    checks++; if (d2_sel[2:0] !== 3'd2) begin errors++; $display("FAIL deep_sel2 got=%0d exp=2", d2_sel[2:0]); end
    tick();
    checks++; if (d2_stall !== 1'b0) begin errors++; $display("FAIL deep_release got=%b exp=0", d2_stall); end
    checks++; if (d2_sel[2:0] !== 3'd3) begin errors++; $display("FAIL deep_sel3 got=%0d exp=3", d2_sel[2:0]); end
    checks++; if (d2_cnt !== 16'd2) begin errors++; $display("FAIL deep_cnt got=%0d exp=2", d2_cnt); end
    checks++; if (d0_cnt !== 16'd1) begin errors++; $display("FAIL shallow_cnt got=%0d exp=1", d0_cnt); end
    tick();
    checks++; if (d2_sel[2:0] !== 3'd4) begin errors++; $display("FAIL deep_sel4 got=%0d exp=4", d2_sel[2:0]); end
    tick();
    checks++; if (d2_sel[2:0] !== 3'd0) begin errors++; $display("FAIL deep_drop got=%0d exp=0", d2_sel[2:0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu_alu();
    test_load_use();
    test_shadow();
    test_zero_flush();
    test_reset_mid();
    test_saturation();
    test_deep_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
